// File: rtl/uart_merge_pkg.sv
// Shared types, frame constants and bit-timing derivation for the UART TX merger.
package uart_merge_pkg;

    localparam int   DATA_BITS   = 8;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    function automatic int calc_bit_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    function automatic int calc_half(input int bit_div);
        return bit_div / 2;
    endfunction

endpackage

// File: rtl/uart_merge_rx.sv
// One source lane: input synchroniser, 8N1 receiver and byte FIFO.
//
// state    | meaning
// RX_IDLE  | line idle, waiting for a falling edge while enabled
// RX_START | half a bit in; confirm the start bit is still low
// RX_DATA  | sample 8 data bits at bit centres, LSB first
// RX_STOP  | sample stop bit; on a low stop bit hold here until the line returns high
module uart_merge_rx
    import uart_merge_pkg::*;
#(
    parameter int BIT_DIV     = 50,
    parameter int HALF        = 25,
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rxd_i,
    input  logic       enable_i,
    input  logic       pop_i,
    output logic       not_empty_o,
    output logic [7:0] rd_data_o,
    output logic       overflow_o,
    output logic       frame_err_o
);

    localparam int CNT_W = $clog2(BIT_DIV);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    rx_state_t              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2:0]             bit_q, bit_d;
    logic [7:0]             shreg_q, shreg_d;
    logic                   wait_q, wait_d;
    logic [7:0]             mem_q [FIFO_DEPTH];
    logic [7:0]             mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]         count_q, count_d;

    logic line;
    logic push;
    logic ferr;
    logic full;
    logic empty;
    logic do_push;
    logic do_pop;

    always_comb begin
        line    = sync_q[SYNC_STAGES-1];
        sync_d  = {sync_q[SYNC_STAGES-2:0], rxd_i};
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        wait_d  = wait_q;
        push    = 1'b0;
        ferr    = 1'b0;

        unique case (state_q)
            RX_IDLE: begin
                if (line == START_LEVEL) begin
                    state_d = RX_START;
                    cnt_d   = CNT_W'(HALF - 1);
                end
            end
            RX_START: begin
                if (cnt_q == '0) begin
                    if (line == START_LEVEL) begin
                        state_d = RX_DATA;
                        cnt_d   = CNT_W'(BIT_DIV - 1);
                        bit_d   = 3'd0;
                    end else begin
                        state_d = RX_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == '0) begin
                    shreg_d = {line, shreg_q[7:1]};
                    cnt_d   = CNT_W'(BIT_DIV - 1);
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'(DATA_BITS - 1)) begin
                        state_d = RX_STOP;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RX_STOP: begin
                if (wait_q) begin
                    if (line == STOP_LEVEL) begin
                        state_d = RX_IDLE;
                        wait_d  = 1'b0;
                    end
                end else if (cnt_q == '0) begin
                    if (line == STOP_LEVEL) begin
                        push    = 1'b1;
                        state_d = RX_IDLE;
                    end else begin
                        ferr   = 1'b1;
                        wait_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase

        // Disabling a lane abandons any partial frame on the spot.
        if (!enable_i) begin
            state_d = RX_IDLE;
            wait_d  = 1'b0;
            push    = 1'b0;
            ferr    = 1'b0;
        end
    end

    always_comb begin
        full     = (count_q == (PTR_W+1)'(FIFO_DEPTH));
        empty    = (count_q == '0);
        do_push  = push && !full;
        do_pop   = pop_i && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = shreg_q;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    assign not_empty_o = !empty;
    assign rd_data_o   = mem_q[rd_ptr_q];
    assign overflow_o  = push && full;
    assign frame_err_o = ferr;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q   <= '1;
            state_q  <= RX_IDLE;
            cnt_q    <= '0;
            bit_q    <= 3'd0;
            shreg_q  <= 8'h00;
            wait_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            sync_q   <= sync_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            wait_q   <= wait_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
        mem_q <= mem_d;
    end

endmodule

// File: rtl/uart_tx_merge.sv
// Merges several UART TX lines onto one pin by re-serialising whole frames round-robin.
//
// state    | meaning
// TX_IDLE  | line high, waiting for any non-empty lane FIFO
// TX_START | driving the start bit for BIT_DIV cycles
// TX_DATA  | driving 8 data bits LSB first
// TX_STOP  | driving the stop bit; last cycle picks the next frame with no gap
module uart_tx_merge
    import uart_merge_pkg::*;
#(
    parameter int NUM_SRC     = 2,
    parameter int CLK_FREQ    = 50000000,
    parameter int BAUD        = 1000000,
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_SRC-1:0] txd_i,
    input  logic [NUM_SRC-1:0] enable_i,
    input  logic               clear_i,
    output logic               txd_o,
    output logic               busy_o,
    output logic [NUM_SRC-1:0] overflow_o,
    output logic [NUM_SRC-1:0] frame_err_o
);

    localparam int BIT_DIV = calc_bit_div(CLK_FREQ, BAUD);
    localparam int HALF    = calc_half(BIT_DIV);
    localparam int CNT_W   = $clog2(BIT_DIV);
    localparam int PTR_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    if (BIT_DIV < 8) begin : g_bad_div
        $error("uart_tx_merge: CLK_FREQ/BAUD must be at least 8");
    end
    if (NUM_SRC < 1 || NUM_SRC > 8) begin : g_bad_num
        $error("uart_tx_merge: NUM_SRC must be 1..8");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_merge: FIFO_DEPTH must be a power of 2, at least 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("uart_tx_merge: SYNC_STAGES must be at least 2");
    end

    logic [NUM_SRC-1:0] not_empty;
    logic [NUM_SRC-1:0] pop;
    logic [NUM_SRC-1:0] ovf_evt;
    logic [NUM_SRC-1:0] ferr_evt;
    logic [7:0]         rd_data [NUM_SRC];

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        uart_merge_rx #(
            .BIT_DIV     (BIT_DIV),
            .HALF        (HALF),
            .FIFO_DEPTH  (FIFO_DEPTH),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_rx (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .rxd_i       (txd_i[i]),
            .enable_i    (enable_i[i]),
            .pop_i       (pop[i]),
            .not_empty_o (not_empty[i]),
            .rd_data_o   (rd_data[i]),
            .overflow_o  (ovf_evt[i]),
            .frame_err_o (ferr_evt[i])
        );
    end

    tx_state_t          tx_state_q, tx_state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shreg_q, shreg_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic               txd_q, txd_d;
    logic               busy_q, busy_d;
    logic [NUM_SRC-1:0] overflow_q, overflow_d;
    logic [NUM_SRC-1:0] frame_err_q, frame_err_d;

    logic               sel_found;
    logic [PTR_W-1:0]   sel_idx;
    logic [PTR_W-1:0]   cand;
    logic               load;

    // Scan starts one past the last served lane so every lane gets a turn.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = ptr_q;
        cand      = ptr_q;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand = PTR_W'((int'(ptr_q) + k) % NUM_SRC);
            if (!sel_found && not_empty[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        ptr_d      = ptr_q;
        txd_d      = txd_q;
        pop        = '0;
        load       = 1'b0;

        unique case (tx_state_q)
            TX_IDLE: begin
                txd_d = STOP_LEVEL;
                load  = sel_found;
            end
            TX_START: begin
                if (cnt_q == '0) begin
                    tx_state_d = TX_DATA;
                    cnt_d      = CNT_W'(BIT_DIV - 1);
                    bit_d      = 3'd0;
                    txd_d      = shreg_q[0];
                    shreg_d    = {1'b0, shreg_q[7:1]};
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            TX_DATA: begin
                if (cnt_q == '0) begin
                    cnt_d = CNT_W'(BIT_DIV - 1);
                    if (bit_q == 3'(DATA_BITS - 1)) begin
                        tx_state_d = TX_STOP;
                        txd_d      = STOP_LEVEL;
                    end else begin
                        txd_d   = shreg_q[0];
                        shreg_d = {1'b0, shreg_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            TX_STOP: begin
                if (cnt_q == '0) begin
                    if (sel_found) begin
                        load = 1'b1;
                    end else begin
                        tx_state_d = TX_IDLE;
                        txd_d      = STOP_LEVEL;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase

        if (load) begin
            pop[sel_idx] = 1'b1;
            shreg_d      = rd_data[sel_idx];
            ptr_d        = sel_idx;
            tx_state_d   = TX_START;
            cnt_d        = CNT_W'(BIT_DIV - 1);
            txd_d        = START_LEVEL;
        end
    end

    always_comb begin
        busy_d      = (tx_state_q != TX_IDLE) || (|not_empty);
        overflow_d  = (clear_i ? '0 : overflow_q) | ovf_evt;
        frame_err_d = (clear_i ? '0 : frame_err_q) | ferr_evt;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_state_q  <= TX_IDLE;
            cnt_q       <= '0;
            bit_q       <= 3'd0;
            shreg_q     <= 8'h00;
            ptr_q       <= PTR_W'(NUM_SRC - 1);
            txd_q       <= STOP_LEVEL;
            busy_q      <= 1'b0;
            overflow_q  <= '0;
            frame_err_q <= '0;
        end else begin
            tx_state_q  <= tx_state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shreg_q     <= shreg_d;
            ptr_q       <= ptr_d;
            txd_q       <= txd_d;
            busy_q      <= busy_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign txd_o       = txd_q;
    assign busy_o      = busy_q;
    assign overflow_o  = overflow_q;
    assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_uart_tx_merge.sv
// Scoreboard bench for uart_tx_merge: drivers push expected bytes, a line monitor decodes txd_o.
`timescale 1ns/1ps
module tb_uart_tx_merge;

    localparam int NUM_SRC     = 2;
    localparam int CLK_FREQ    = 50000000;
    localparam int BAUD        = 1000000;
    localparam int FIFO_DEPTH  = 16;
    localparam int SYNC_STAGES = 2;
    localparam int BIT_DIV     = 50;
    localparam int HALF        = 25;
    // drive-to-output: 2 sync + 1 idle->start + 25 half bit + 9 bits*50 to stop centre + 1 to txd_o
    localparam int LATENCY     = 479;

    logic               clk = 1'b0;
    logic               rst_i;
    logic [NUM_SRC-1:0] txd_i;
    logic [NUM_SRC-1:0] enable_i;
    logic               clear_i;
    logic               txd_o;
    logic               busy_o;
    logic [NUM_SRC-1:0] overflow_o;
    logic [NUM_SRC-1:0] frame_err_o;

    uart_tx_merge #(
        .NUM_SRC     (NUM_SRC),
        .CLK_FREQ    (CLK_FREQ),
        .BAUD        (BAUD),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .txd_i       (txd_i),
        .enable_i    (enable_i),
        .clear_i     (clear_i),
        .txd_o       (txd_o),
        .busy_o      (busy_o),
        .overflow_o  (overflow_o),
        .frame_err_o (frame_err_o)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q [$];
    logic [7:0] rx_log [$];
    int         start_log [$];
    int         frames_seen = 0;
    bit         mon_en = 1'b1;
    bit         ovf_mode = 1'b0;
    int         idle_cyc = 0;
    int         drv_cyc;
    int         snap;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic send_byte(input int s, input logic [7:0] d, input logic stop);
        logic [9:0] fr;
        fr = {stop, d, 1'b0};
        for (int b = 0; b < 10; b++) begin
            txd_i[s] = fr[b];
            repeat (BIT_DIV) @(posedge clk);
            #1;
        end
        txd_i[s] = 1'b1;
    endtask

    task automatic wait_idle(input int max_cyc);
        bit done;
        done = 1'b0;
        for (int i = 0; i < max_cyc && !done; i++) begin
            @(negedge clk);
            if (!busy_o) begin
                done     = 1'b1;
                idle_cyc = cyc;
            end
        end
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_idle: busy_o still high after %0d cycles", max_cyc);
        end
        repeat (5) @(negedge clk);
    endtask

    // Line monitor: decodes each frame on txd_o at bit centres.
    logic [7:0] mon_b;
    logic       mon_stop;
    int         mon_c0;
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rst_i && txd_o == 1'b0) begin
                mon_c0 = cyc;
                start_log.push_back(mon_c0);
                repeat (HALF) @(negedge clk);
                for (int j = 0; j < 8; j++) begin
                    repeat (BIT_DIV) @(negedge clk);
                    mon_b[j] = txd_o;
                end
                repeat (BIT_DIV) @(negedge clk);
                mon_stop = txd_o;
                if (mon_en) begin
                    frames_seen++;
                    check("stop_bit", mon_stop, 1'b1);
                    if (ovf_mode) begin
                        rx_log.push_back(mon_b);
                    end else if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_byte: got 0x%0h, expected no frame", mon_b);
                    end else begin
                        check("out_byte", mon_b, exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #4000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int last0, last1, n0, n1;
        bit ok;
        txd_i    = '1;
        enable_i = '1;
        clear_i  = 1'b0;
        rst_i    = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_txd", txd_o, 1'b1);
        check("rst_busy", busy_o, 1'b0);
        check("rst_ovf", overflow_o, 2'b00);
        check("rst_ferr", frame_err_o, 2'b00);
        @(posedge clk); #1;
        rst_i = 1'b0;

        // single byte from src0
        start_log.delete();
        exp_q.push_back(8'h55);
        @(posedge clk); #1;
        drv_cyc = cyc;
        send_byte(0, 8'h55, 1'b1);
        @(negedge clk);
        check("busy_mid_frame", busy_o, 1'b1);
        wait_idle(2000);
        check("single_pending", exp_q.size(), 0);
        check("single_frames", start_log.size(), 1);
        if (start_log.size() > 0) begin
            check("latency", start_log[0] - drv_cyc, LATENCY);
            check("busy_fall", idle_cyc - start_log[0], 10 * BIT_DIV + 1);
        end

        // fresh pointer: src0 wins first
        @(posedge clk); #1 rst_i = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;

        start_log.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h3C);
        @(posedge clk); #1;
        fork
            send_byte(0, 8'hA5, 1'b1);
            send_byte(1, 8'h3C, 1'b1);
        join
        wait_idle(3000);
        check("contend1_pending", exp_q.size(), 0);
        check("contend1_frames", start_log.size(), 2);
        if (start_log.size() == 2) check("b2b_gap", start_log[1] - start_log[0], 10 * BIT_DIV);

        // src0 alone moves the pointer to 0, so src1 wins the next contention
        exp_q.push_back(8'h0F);
        @(posedge clk); #1;
        send_byte(0, 8'h0F, 1'b1);
        wait_idle(2000);
        exp_q.push_back(8'h96);
        exp_q.push_back(8'hF0);
        @(posedge clk); #1;
        fork
            send_byte(0, 8'hF0, 1'b1);
            send_byte(1, 8'h96, 1'b1);
        join
        wait_idle(3000);
        check("contend2_pending", exp_q.size(), 0);

        // enable dropped mid-frame: nothing pushed
        snap = frames_seen;
        @(posedge clk); #1;
        fork
            send_byte(0, 8'h42, 1'b1);
            begin
                repeat (250) @(posedge clk);
                #1 enable_i[0] = 1'b0;
            end
        join
        enable_i[0] = 1'b1;
        repeat (600) @(negedge clk);
        check("enable_busy", busy_o, 1'b0);
        check("enable_frames", frames_seen - snap, 0);
        check("enable_ferr", frame_err_o, 2'b00);

        // overflow: both lanes stream 40 bytes back to back
        ovf_mode = 1'b1;
        rx_log.delete();
        @(posedge clk); #1;
        fork
            for (int i = 0; i < 40; i++) send_byte(0, 8'(i), 1'b1);
            for (int i = 0; i < 40; i++) send_byte(1, 8'(8'h80 + i), 1'b1);
        join
        @(negedge clk);
        check("ovf_flags", overflow_o, 2'b11);
        wait_idle(40000);
        ovf_mode = 1'b0;
        ok = 1'b1; last0 = -1; last1 = -1; n0 = 0; n1 = 0;
        foreach (rx_log[k]) begin
            if (!rx_log[k][7]) begin
                if (int'(rx_log[k]) > 39 || int'(rx_log[k]) <= last0) ok = 1'b0;
                last0 = int'(rx_log[k]);
                n0++;
            end else begin
                if (int'(rx_log[k]) - 128 > 39 || int'(rx_log[k]) - 128 <= last1) ok = 1'b0;
                last1 = int'(rx_log[k]) - 128;
                n1++;
            end
        end
        check("ovf_order", ok, 1'b1);
        check("ovf_src0_min", (n0 >= FIFO_DEPTH), 1'b1);
        check("ovf_src1_min", (n1 >= FIFO_DEPTH), 1'b1);
        check("ovf_ferr", frame_err_o, 2'b00);
        @(posedge clk); #1 clear_i = 1'b1;
        @(posedge clk); #1 clear_i = 1'b0;
        @(negedge clk);
        check("clear_ovf", overflow_o, 2'b00);

        // frame error on src1, then a short glitch on src0
        snap = frames_seen;
        @(posedge clk); #1;
        send_byte(1, 8'h77, 1'b0);
        repeat (20) @(negedge clk);
        check("ferr_set", frame_err_o, 2'b10);
        @(posedge clk); #1 txd_i[0] = 1'b0;
        repeat (BIT_DIV / 4) @(posedge clk);
        #1 txd_i[0] = 1'b1;
        repeat (600) @(negedge clk);
        check("glitch_ferr", frame_err_o, 2'b10);
        check("glitch_ovf", overflow_o, 2'b00);
        check("ferr_glitch_frames", frames_seen - snap, 0);
        check("ferr_glitch_busy", busy_o, 1'b0);

        // reset in the middle of an output frame with another byte queued
        mon_en = 1'b0;
        @(posedge clk); #1;
        fork
            send_byte(0, 8'h5A, 1'b1);
            send_byte(1, 8'h33, 1'b1);
        join
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("pre_rst_txd_low", txd_o, 1'b0);
        @(posedge clk); #1 rst_i = 1'b1;
        @(posedge clk); #1 rst_i = 1'b0;
        @(negedge clk);
        check("post_rst_txd", txd_o, 1'b1);
        check("post_rst_ferr", frame_err_o, 2'b00);
        check("post_rst_ovf", overflow_o, 2'b00);
        repeat (2) @(negedge clk);
        check("post_rst_busy", busy_o, 1'b0);
        repeat (600) @(negedge clk);
        mon_en = 1'b1;
        snap = frames_seen;
        repeat (1200) @(negedge clk);
        check("post_rst_frames", frames_seen - snap, 0);
        check("post_rst_idle_busy", busy_o, 1'b0);
        check("post_rst_idle_txd", txd_o, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
